mdv_unit: RTL and testbench

- EX-stage multiply/divide unit with architectural HI/LO registers.
- Consumes the decoded MDV operation and start strobe produced by the ID-stage control decoder and carried through the ID/EX register.
- Models fixed multi-cycle latency for mult/multu/div/divu and raises busy so the hazard unit stalls later HI/LO users.
- Serves mthi/mtlo writes and mfhi/mflo reads, whose read value goes to the EX answer mux.

---
 rtl/databus.sv | 21 ++
 rtl/mdv_unit.sv | 142 ++++++++++++++
 tb/tb_mdv_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/databus.sv
// Shared datapath typedefs: multiply/divide operation codes and the MDV unit state.
package databus;

    typedef enum logic [3:0] {
        MDV_mult,
        MDV_multu,
        MDV_div,
        MDV_divu,
        MDV_mthi,
        MDV_mtlo,
        MDV_mfhi,
        MDV_mflo,
        MDV_none
    } MDVOP;

    typedef enum logic {
        IDLE,
        RUN
    } MDVSTATE;

endpackage

// File: rtl/mdv_unit.sv
// EX-stage multiply/divide unit: fixed-latency mult/div with HI/LO architectural registers.
module mdv_unit
    import databus::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  MDVOP        MDVop,
    input  logic        start,
    input  logic        Req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDV_out
);

    // The issue cycle is the first busy cycle, so the RUN countdown starts at N-1.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    MDVSTATE          state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             divz_q, divz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic             is_mul, is_div;
    logic [31:0]      res_hi, res_lo;
    logic [63:0]      prod_s, prod_u;
    logic [31:0]      b_safe;
    logic signed [31:0] quot_s, rem_s;

    assign is_mul = (MDVop == MDV_mult) || (MDVop == MDV_multu);
    assign is_div = (MDVop == MDV_div)  || (MDVop == MDV_divu);

    // Divisor is forced nonzero so the divide-by-zero path never produces X.
    assign b_safe = (B == 32'd0) ? 32'd1 : B;
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign quot_s = $signed(A) / $signed(b_safe);
    assign rem_s  = $signed(A) % $signed(b_safe);

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (MDVop)
            MDV_mult:  {res_hi, res_lo} = prod_s;
            MDV_multu: {res_hi, res_lo} = prod_u;
            MDV_div: begin
                res_hi = rem_s;
                res_lo = quot_s;
            end
            MDV_divu: begin
                res_hi = A % b_safe;
                res_lo = A / b_safe;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        divz_d    = divz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (!Req) begin
                    if (start && (is_mul || is_div)) begin
                        pend_hi_d = res_hi;
                        pend_lo_d = res_lo;
                        divz_d    = is_div && (B == 32'd0);
                        count_d   = is_mul ? MULT_LOAD : DIV_LOAD;
                        if (count_d == '0) begin
                            // Single-cycle latency: commit straight from the issue cycle.
                            if (!divz_d) begin
                                hi_d = res_hi;
                                lo_d = res_lo;
                            end
                        end else begin
                            state_d = RUN;
                        end
                    end else if (MDVop == MDV_mthi) begin
                        hi_d = A;
                    end else if (MDVop == MDV_mtlo) begin
                        lo_d = A;
                    end
                end
            end
            RUN: begin
                if (count_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    count_d = '0;
                    if (!divz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            divz_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            divz_q    <= divz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy    = start | (state_q == RUN);
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign MDV_out = (MDVop == MDV_mfhi) ? hi_q :
                     (MDVop == MDV_mflo) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdv_unit.sv
// Directed bench for mdv_unit: table of arithmetic vectors plus hand-written corner sequences.
module tb_mdv_unit;
    import databus::*;

    logic        clk;
    logic        reset;
    MDVOP        MDVop;
    logic        start;
    logic        Req;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDV_out;

    int checks;
    int errors;

    mdv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .MDVop(MDVop), .start(start), .Req(Req),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .MDV_out(MDV_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        MDVOP        op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MDVop = MDV_none;
        start = 1'b0;
        Req   = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
    endtask

    // Issue one operation and verify busy for n cycles, then idle and the result.
    task automatic run_op(input vec_t v, input int req_cycle);
        for (int i = 0; i < v.n; i++) begin
            if (i == 0) begin
                MDVop = v.op; start = 1'b1; A = v.a; B = v.b;
            end else begin
                idle_inputs();
            end
            Req = (i == req_cycle);
            #1;
            check($sformatf("busy op%0d cyc%0d", v.op, i), {31'd0, busy}, 32'd1);
            tick();
        end
        idle_inputs();
        #1;
        check($sformatf("busy_done op%0d", v.op), {31'd0, busy}, 32'd0);
        check($sformatf("HI op%0d", v.op), HI, v.exp_hi);
        check($sformatf("LO op%0d", v.op), LO, v.exp_lo);
    endtask

    vec_t vecs[8];

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1'b1;

        vecs[0] = '{MDV_mult,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{MDV_multu, 32'hFFFF_FFFE, 32'd3,         5,  32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{MDV_div,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{MDV_divu,  32'd7,         32'd0,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{MDV_mult,  32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};
        vecs[5] = '{MDV_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[6] = '{MDV_divu,  32'd100,       32'd7,         10, 32'd2,         32'd14};
        vecs[7] = '{MDV_div,   32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD};

        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        check("reset MDV_out", MDV_out, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], -1);
        end

        // mthi followed by mfhi sees the written value; mflo reads LO.
        MDVop = MDV_mthi; A = 32'h1234_5678;
        tick();
        idle_inputs();
        MDVop = MDV_mfhi;
        #1;
        check("mfhi after mthi", MDV_out, 32'h1234_5678);
        MDVop = MDV_mflo;
        #1;
        check("mflo", MDV_out, 32'hFFFF_FFFD);
        MDVop = MDV_mult;
        #1;
        check("MDV_out non-read", MDV_out, 32'd0);

        // mtlo cancelled by Req must not write.
        MDVop = MDV_mtlo; A = 32'hDEAD_BEEF; Req = 1'b1;
        tick();
        idle_inputs();
        MDVop = MDV_mflo;
        #1;
        check("mtlo with Req", LO, 32'hFFFF_FFFD);
        MDVop = MDV_mtlo; A = 32'hCAFE_0001;
        tick();
        idle_inputs();
        #1;
        check("mtlo write", LO, 32'hCAFE_0001);

        // start together with Req: busy only that cycle, nothing issued.
        MDVop = MDV_mult; start = 1'b1; Req = 1'b1; A = 32'd3; B = 32'd5;
        #1;
        check("req-start busy", {31'd0, busy}, 32'd1);
        tick();
        idle_inputs();
        #1;
        check("req-start busy next", {31'd0, busy}, 32'd0);
        repeat (6) tick();
        check("req-start HI", HI, 32'h1234_5678);
        check("req-start LO", LO, 32'hCAFE_0001);

        // Req pulse during RUN of a div does not cancel it.
        run_op('{MDV_div, 32'hFFFF_FF9C, 32'd7, 10, 32'hFFFF_FFFE, 32'hFFFF_FFF2}, 3);

        // Reset in cycle 3 of a mult aborts it.
        MDVop = MDV_mult; start = 1'b1; A = 32'd3; B = 32'd5;
        tick();
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort HI", HI, 32'd0);
        check("abort LO", LO, 32'd0);
        repeat (8) tick();
        check("abort late HI", HI, 32'd0);
        check("abort late LO", LO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
